// File: rtl/apb_master.sv
// APB initiator: takes one CPU load/store request at a time, decodes it to
// one of NUM_SLAVES peripheral slots inside a 64 KB window and runs the
// APB SETUP/ACCESS handshake. Completion is a one-cycle ready pulse with
// read data, or with err set on a decode miss or a PREADY timeout.
module apb_master #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       req,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic                       we,
  output logic [31:0]                rdata,
  output logic                       ready,
  output logic                       err,
  output logic [31:0]                PADDR,
  output logic [31:0]                PWDATA,
  output logic                       PWRITE,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [NUM_SLAVES*32-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  localparam int unsigned   CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_hit;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;

  // Address decode: one-hot slot select; a slot index past NUM_SLAVES
  // leaves dec_sel empty, which doubles as the range check.
  always_comb begin
    dec_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      dec_sel[i] = (addr[15:12] == 4'(i));
    end
    dec_hit = (addr[31:16] == BASE_ADDR[31:16]) && (|dec_sel);
  end

  // Return-path mux: the registered PSEL acts as the latched slot index,
  // so PREADY/PRDATA of non-selected slots never reach the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) begin
        sel_ready = sel_ready | PREADY[i];
        sel_rdata = sel_rdata | PRDATA[32*i +: 32];
      end
    end
  end

  // Transfer FSM with all bus and CPU-side outputs registered.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PENABLE <= 1'b0;
      PSEL    <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (dec_hit) begin
              PADDR  <= addr;
              PWDATA <= wdata;
              PWRITE <= we;
              PSEL   <= dec_sel;
              state  <= SETUP;
            end else begin
              rdata <= '0;
              err   <= 1'b1;
              ready <= 1'b1;
              state <= DONE;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is tested first so a slave answering on the last
          // permitted cycle still completes normally.
          if (sel_ready) begin
            rdata   <= PWRITE ? '0 : sel_rdata;
            err     <= 1'b0;
            ready   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= DONE;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            rdata   <= '0;
            err     <= 1'b1;
            ready   <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= DONE;
          end else if (TIMEOUT_EN) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed and randomized transfers against a
// transaction-level reference model, with a scoreboard-driven slave model
// and a monitor that checks each completion and the APB phase sequence.
module tb_apb_master;

  localparam int unsigned NS  = 4;
  localparam int unsigned TMO = 16;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             req;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             we;
  logic [31:0]      rdata;
  logic             ready;
  logic             err;
  logic [31:0]      PADDR;
  logic [31:0]      PWDATA;
  logic             PWRITE;
  logic             PENABLE;
  logic [NS-1:0]    PSEL;
  logic [NS*32-1:0] PRDATA;
  logic [NS-1:0]    PREADY;

  apb_master #(
    .NUM_SLAVES(NS),
    .BASE_ADDR (32'h1000_0000),
    .TIMEOUT   (TMO)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .req    (req),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PWRITE (PWRITE),
    .PENABLE(PENABLE),
    .PSEL   (PSEL),
    .PRDATA (PRDATA),
    .PREADY (PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int unsigned wait_n;      // PREADY-low ACCESS cycles the slave inserts
    logic [31:0] slave_data;  // what the selected slave drives on PRDATA
    bit          hit;
    int unsigned slot;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int unsigned lat;         // cycles from acceptance edge to ready
    int unsigned exp_setup;
    int unsigned exp_access;
    int unsigned exp_cyc;
  } txn_t;

  txn_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned setup_n = 0;
  int unsigned access_n = 0;
  int unsigned apb_bad = 0;
  int unsigned psel_multi = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outcome of a transfer from the address map, the slave's
  // wait count and the timeout limit.
  function automatic txn_t model(input logic [31:0] a, input logic [31:0] d, input logic w,
                                 input int unsigned wt, input logic [31:0] sd);
    txn_t t;
    t.addr = a; t.wdata = d; t.we = w; t.wait_n = wt; t.slave_data = sd;
    t.slot = int'(a[15:12]);
    t.hit  = (a[31:16] == 16'h1000) && (t.slot < NS);
    t.exp_cyc = 0;
    if (!t.hit) begin
      t.exp_err = 1'b1; t.exp_rdata = '0; t.lat = 1; t.exp_setup = 0; t.exp_access = 0;
    end else if (wt < TMO) begin
      t.exp_err = 1'b0; t.exp_rdata = w ? 32'h0 : sd;
      t.lat = 3 + wt; t.exp_setup = 1; t.exp_access = wt + 1;
    end else begin
      t.exp_err = 1'b1; t.exp_rdata = '0;
      t.lat = 2 + TMO; t.exp_setup = 1; t.exp_access = TMO;
    end
    return t;
  endfunction

  // Slave model and monitor: watches the bus each cycle, answers for the
  // transfer at the head of the scoreboard, and scores every ready pulse.
  initial begin
    txn_t        h;
    bit          has;
    logic [NS-1:0] exp_sel;
    PREADY = '0;
    PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESET) begin
        setup_n = 0; access_n = 0; apb_bad = 0;
        PREADY = '0;
      end else begin
        has = (sb.size() != 0);
        if (has) h = sb[0];
        if (!$onehot0(PSEL)) psel_multi++;
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
        PREADY = NS'($urandom);
        exp_sel = '0;
        if (has && h.hit) begin
          PRDATA[32*h.slot +: 32] = h.slave_data;
          PREADY[h.slot] = 1'b0;
          exp_sel[h.slot] = 1'b1;
        end
        if (PSEL != '0 || PENABLE) begin
          if (!has || !h.hit || PSEL != exp_sel || PADDR != h.addr || PWRITE != h.we ||
              (h.we && PWDATA != h.wdata)) apb_bad++;
          if (PENABLE) begin
            if (setup_n == 0) apb_bad++;
            if (has && h.hit) PREADY[h.slot] = (access_n == h.wait_n);
            access_n++;
          end else begin
            if (access_n != 0) apb_bad++;
            setup_n++;
          end
        end
        if (ready) begin
          if (!has) begin
            check("spurious_ready", 32'(ready), 32'd0);
          end else begin
            check("err", 32'(err), 32'(h.exp_err));
            check("rdata", rdata, h.exp_rdata);
            check("ready_cycle", 32'(cyc), 32'(h.exp_cyc));
            check("setup_cycles", 32'(setup_n), 32'(h.exp_setup));
            check("access_cycles", 32'(access_n), 32'(h.exp_access));
            check("apb_phase_fields", 32'(apb_bad), 32'd0);
            void'(sb.pop_front());
          end
          setup_n = 0; access_n = 0; apb_bad = 0;
        end
      end
    end
  end

  task automatic wait_done();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge PCLK); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("completion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input txn_t t);
    @(negedge PCLK); #1;
    req = 1'b1; addr = t.addr; wdata = t.wdata; we = t.we;
    t.exp_cyc = cyc + t.lat;
    sb.push_back(t);
    @(negedge PCLK); #1;
    req = 1'b0; addr = $urandom; wdata = $urandom; we = 1'($urandom);
  endtask

  task automatic run(input txn_t t);
    issue(t);
    wait_done();
  endtask

  initial begin
    txn_t t1, t2;
    logic [31:0] a;
    int unsigned wt;
    PRESET = 1'b0; req = 1'b0; addr = '0; wdata = '0; we = 1'b0;
    #3;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    @(negedge PCLK); @(negedge PCLK); #2;
    PRESET = 1'b1;

    // Directed cases
    run(model(32'h1000_0008, 32'h0000_0003, 1'b1, 0, 32'h0));
    run(model(32'h1000_2004, 32'h0, 1'b0, 3, 32'hCAFE_0123));
    run(model(32'h2000_0000, 32'h0, 1'b0, 0, 32'h1111_1111));
    run(model(32'h1000_5000, 32'h0, 1'b0, 0, 32'h2222_2222));
    run(model(32'h1000_1000, 32'h0, 1'b0, 100, 32'h3333_3333));
    run(model(32'h1000_1010, 32'h0, 1'b0, TMO - 1, 32'h4444_5555));
    run(model(32'h1000_F000, 32'h5, 1'b1, 0, 32'h0));

    // Reset while in ACCESS: outputs clear at once, no completion follows
    issue(model(32'h1000_1020, 32'h0, 1'b0, 100, 32'h6666_7777));
    @(negedge PCLK); @(negedge PCLK); #2;
    check("pre_rst_psel", 32'(PSEL), 32'h2);
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    PRESET = 1'b0;
    #1;
    check("mid_rst_psel", 32'(PSEL), 32'd0);
    check("mid_rst_penable", 32'(PENABLE), 32'd0);
    check("mid_rst_paddr", PADDR, 32'd0);
    check("mid_rst_pwdata", PWDATA, 32'd0);
    check("mid_rst_pwrite", 32'(PWRITE), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    sb.delete();
    @(negedge PCLK); #2;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    run(model(32'h1000_1040, 32'h0, 1'b0, 1, 32'h89AB_CDEF));

    // Back-to-back with req held: write slot 0, then read slot 3
    t1 = model(32'h1000_0100, 32'hA5A5_0001, 1'b1, 0, 32'h0);
    t2 = model(32'h1000_3200, 32'h0, 1'b0, 2, 32'h1357_9BDF);
    @(negedge PCLK); #1;
    req = 1'b1; addr = t1.addr; wdata = t1.wdata; we = t1.we;
    t1.exp_cyc = cyc + t1.lat;
    sb.push_back(t1);
    @(negedge PCLK); #1;
    addr = t2.addr; wdata = t2.wdata; we = t2.we;
    repeat (3) begin @(negedge PCLK); #1; end
    t2.exp_cyc = cyc + t2.lat;
    sb.push_back(t2);
    @(negedge PCLK); #1;
    req = 1'b0;
    wait_done();

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        if ($urandom_range(0, 1) == 1)
          a = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
        else begin
          a = $urandom;
          if (a[31:16] == 16'h1000) a[31:16] = 16'h2000;
        end
      end else begin
        a = {16'h1000, 4'($urandom_range(0, 3)), 12'($urandom)};
      end
      wt = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(13, 18);
      run(model(a, $urandom, 1'($urandom), wt, $urandom));
    end

    repeat (4) @(negedge PCLK);
    check("psel_multi_hot", 32'(psel_multi), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
